pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Program counter / fetch sequencer directly upstream of the branch-target LUT.
//   Forwards the decoder's 6-bit jump index to the LUT and takes back the D-bit absolute target.
//   Each cycle it selects the next PC: hold, increment, or taken jump.
//   Runs an IDLE/RUN/HALT controller, where a jump to DONE_ADDR (LUT entry 0) raises done.
// PARAMETERS
//   D            12      PC / target width
//   DONE_ADDR    2**D-1  halt sentinel target (4095 at default D)
//   STACK_DEPTH  4       return-address stack entries (used only with PC_CALL_STACK_EN)
//   CNT_W        16      width of retired-instruction counter
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-high reset
//   start       in   1      pulse: begin or restart program at PC 0
//   stall       in   1      hold PC this cycle
//   jmp_idx     in   6      LUT index from decoder
//   jump_en     in   1      unconditional jump request
//   branch_en   in   1      conditional branch request
//   cond        in   1      branch condition (taken = branch_en & cond)
//   call_en     in   1      call request (jump plus push)
//   ret_en      in   1      return request (pop)
//   lut_addr    out  6      = jmp_idx, combinational pass-through to LUT addr
//   lut_target  in   D      LUT target for lut_addr
//   pc          out  D      current PC to instruction memory
//   running     out  1      1 in RUN state
//   done        out  1      1 in HALT state
//   retired     out  CNT_W  count of advancing RUN cycles, saturating
//   stack_err   out  1      sticky stack overflow/underflow flag
// BEHAVIOUR
//   - Reset (sync): state=IDLE, pc=0, done=0, running=0, retired=0, stack_err=0, stack empty.
//     Reset mid-RUN aborts on the next edge with no other side effect.
//   - IDLE: pc holds 0. On start: ->RUN, pc=0.
//   - RUN: one next-PC decision per cycle, registered (1-cycle latency). Priority:
//     1. stall: pc, stack and retired hold; all requests are dropped. Decoder re-presents them.
//     2. ret_en: see CONFIGURATION.
//     3. take = jump_en | call_en | (branch_en & cond):
//        - if lut_target==DONE_ADDR: ->HALT, pc holds.
//        - otherwise pc=lut_target.
//     4. else pc=pc+1 mod 2**D. If the result equals DONE_ADDR: ->HALT, pc=DONE_ADDR.
//     Every non-stall RUN cycle increments retired by 1, saturating at all-ones.
//   - Unmapped LUT index returns target 0; this is a legal jump to PC 0, not an error.
//   - HALT: done=1, running=0, pc frozen; all requests ignored. start -> RUN with pc=0,
//     retired=0, done=0, stack_err=0 and the stack emptied.
//   - start in RUN: ignored. start together with stall in IDLE/HALT: start still wins.
//   - Multiple requests in the same cycle: resolved purely by the priority list above.
// CONFIGURATION
//   Macro PC_CALL_STACK_EN.
//   Defined:
//     - call_en pushes pc+1 onto a STACK_DEPTH LIFO and jumps to lut_target.
//     - ret_en pops the LIFO into pc.
//     - Push when full: push dropped, jump still taken, stack_err=1.
//     - Pop when empty: pc=pc+1, stack_err=1.
//     - call_en to DONE_ADDR: halts, no push.
//   Undefined:
//     - No stack storage.
//     - call_en behaves as jump_en.
//     - ret_en is ignored (falls through to the next priority).
//     - stack_err is tied to 0.
// TESTING
//   1. reset; start; no requests for 5 cycles -> pc 0,1,2,3,4,5; retired=5; running=1.
//   2. At pc=3: branch_en=1, cond=1, jmp_idx=2, lut_target=34 -> pc=34 next cycle.
//      Same with cond=0 -> pc=4.
//   3. jump_en=1, jmp_idx=0, lut_target=4095 -> done=1, pc frozen at its prior value;
//      requests ignored; start -> pc=0, done=0, retired=0.
//   4. stall=1 with jump_en=1 for 3 cycles -> pc and retired unchanged.
//      Release stall -> jump taken.
//      reset asserted mid-RUN -> pc=0, state IDLE next edge.
//   5. pc forced by jump to 4093, then free-run -> 4094, then 4095 with done=1.
//   6. (PC_CALL_STACK_EN) Call at pc=10 to 50, then ret -> pc=11.
//      5 nested calls with DEPTH=4 -> stack_err=1.
//      Ret on empty stack -> pc+1 and stack_err=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter / fetch sequencer with IDLE/RUN/HALT control in front of the branch-target LUT.
// Defining PC_CALL_STACK_EN adds a STACK_DEPTH-entry return-address stack for call_en/ret_en.
module pc_sequencer #(
    parameter int unsigned  D           = 12,
    parameter logic [D-1:0] DONE_ADDR   = {D{1'b1}},
    parameter int unsigned  STACK_DEPTH = 4,
    parameter int unsigned  CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic [5:0]       jmp_idx,
    input  logic             jump_en,
    input  logic             branch_en,
    input  logic             cond,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [5:0]       lut_addr,
    input  logic [D-1:0]     lut_target,
    output logic [D-1:0]     pc,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] retired,
    output logic             stack_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t           state_q, state_d;
    logic [D-1:0]     pc_q, pc_d, pc_inc;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             stack_err_q, stack_err_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             take, do_inc;
    logic             ret_sel, call_sel, ret_ok, push_ok;
    logic [D-1:0]     ret_pc;

    assign lut_addr  = jmp_idx;
    assign pc_inc    = pc_q + D'(1);
    assign take      = jump_en | call_en | (branch_en & cond);

    assign pc        = pc_q;
    assign running   = running_q;
    assign done      = done_q;
    assign retired   = retired_q;
    assign stack_err = stack_err_q;

`ifdef PC_CALL_STACK_EN
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [D-1:0]     stack_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d, sp_dec;
    logic [IDX_W-1:0] push_idx, pop_idx;
    logic             stack_full, stack_empty, adv, push, pop;

    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign sp_dec      = sp_q - SP_W'(1);
    assign push_idx    = sp_q[IDX_W-1:0];
    assign pop_idx     = sp_dec[IDX_W-1:0];

    assign ret_sel  = ret_en;
    assign call_sel = call_en;
    assign ret_ok   = !stack_empty;
    assign push_ok  = !stack_full;
    assign ret_pc   = stack_q[pop_idx];

    // A call that halts on DONE_ADDR never pushes; ret outranks call.
    assign adv  = (state_q == S_RUN) && !stall;
    assign pop  = adv && ret_en && !stack_empty;
    assign push = adv && !ret_en && call_en && (lut_target != DONE_ADDR) && !stack_full;

    always_comb begin
        sp_d = sp_q;
        if ((state_q != S_RUN) && start) begin
            sp_d = '0;
        end else if (push) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop) begin
            sp_d = sp_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
            if (push) begin
                stack_q[push_idx] <= pc_inc;
            end
        end
    end
`else
    logic unused_ret;

    assign unused_ret = ret_en;
    assign ret_sel    = 1'b0;
    assign call_sel   = 1'b0;
    assign ret_ok     = 1'b0;
    assign push_ok    = 1'b1;
    assign ret_pc     = '0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        retired_d   = retired_q;
        stack_err_d = stack_err_q;
        do_inc      = 1'b0;

        case (state_q)
            S_RUN: begin
                if (!stall) begin
                    if (retired_q != '1) begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                    if (ret_sel) begin
                        if (ret_ok) begin
                            pc_d = ret_pc;
                        end else begin
                            stack_err_d = 1'b1;
                            do_inc      = 1'b1;
                        end
                    end else if (take) begin
                        if (lut_target == DONE_ADDR) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d = lut_target;
                            if (call_sel && !push_ok) begin
                                stack_err_d = 1'b1;
                            end
                        end
                    end else begin
                        do_inc = 1'b1;
                    end
                    // Free-running into the sentinel address halts with pc parked on it.
                    if (do_inc) begin
                        pc_d = pc_inc;
                        if (pc_inc == DONE_ADDR) begin
                            state_d = S_HALT;
                        end
                    end
                end
            end
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d     = S_RUN;
                    pc_d        = '0;
                    retired_d   = '0;
                    stack_err_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            retired_q   <= '0;
            stack_err_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            retired_q   <= retired_d;
            stack_err_q <= stack_err_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic against a queue-based model.
// Stack scenarios are exercised when PC_CALL_STACK_EN is defined.
module tb_pc_sequencer;

    localparam int DONE    = 4095;
    localparam int DEPTH   = 4;
    localparam int CNT_MAX = 65535;
`ifdef PC_CALL_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic        clk;
    logic        reset, start, stall, jump_en, branch_en, cond, call_en, ret_en;
    logic [5:0]  jmp_idx, lut_addr;
    logic [11:0] lut_target, pc;
    logic        running, done, stack_err;
    logic [15:0] retired;
    logic [11:0] lut_mem [64];

    int errors;
    int checks;

    int m_pc;
    int m_retired;
    bit m_running;
    bit m_done;
    bit m_err;
    int m_stack [$];

    int saved_pc;
    int saved_ret;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .jmp_idx    (jmp_idx),
        .jump_en    (jump_en),
        .branch_en  (branch_en),
        .cond       (cond),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .lut_addr   (lut_addr),
        .lut_target (lut_target),
        .pc         (pc),
        .running    (running),
        .done       (done),
        .retired    (retired),
        .stack_err  (stack_err)
    );

    assign lut_target = lut_mem[lut_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_advance();
        m_pc = (m_pc + 1) % 4096;
        if (m_pc == DONE) begin
            m_running = 1'b0;
            m_done    = 1'b1;
        end
    endfunction

    function automatic void model_step();
        int tgt;
        tgt = int'(lut_mem[jmp_idx]);
        if (reset) begin
            m_pc = 0; m_retired = 0; m_running = 0; m_done = 0; m_err = 0;
            m_stack.delete();
            return;
        end
        if (!m_running) begin
            if (start) begin
                m_pc = 0; m_retired = 0; m_running = 1; m_done = 0; m_err = 0;
                m_stack.delete();
            end
            return;
        end
        if (stall) return;
        if (m_retired < CNT_MAX) m_retired++;
        if (STACK_EN && ret_en) begin
            if (m_stack.size() == 0) begin
                m_err = 1'b1;
                model_advance();
            end else begin
                m_pc = m_stack.pop_back();
            end
            return;
        end
        if (jump_en || call_en || (branch_en && cond)) begin
            if (tgt == DONE) begin
                m_running = 1'b0;
                m_done    = 1'b1;
                return;
            end
            if (STACK_EN && call_en) begin
                if (m_stack.size() == DEPTH) m_err = 1'b1;
                else m_stack.push_back((m_pc + 1) % 4096);
            end
            m_pc = tgt;
            return;
        end
        model_advance();
    endfunction

    task automatic clear_requests();
        start = 0; stall = 0; jump_en = 0; branch_en = 0; cond = 0;
        call_en = 0; ret_en = 0; jmp_idx = 6'd0;
    endtask

    task automatic applyStimulus();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check_val({tag, ".pc"},        32'(pc),        32'(m_pc));
        check_val({tag, ".running"},   32'(running),   32'(m_running));
        check_val({tag, ".done"},      32'(done),      32'(m_done));
        check_val({tag, ".retired"},   32'(retired),   32'(m_retired));
        check_val({tag, ".stack_err"}, 32'(stack_err), 32'(m_err));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_pc = 0; m_retired = 0; m_running = 0; m_done = 0; m_err = 0;
        for (int i = 0; i < 64; i++) lut_mem[i] = 12'd0;
        lut_mem[0] = 12'd4095;
        clear_requests();

        @(negedge clk);
        reset = 1;
        applyStimulus();
        applyStimulus();
        reset = 0;
        checkOutput("reset");
        check_val("reset.pc0", 32'(pc), 0);

        // Test 1: free run from start
        start = 1;
        applyStimulus();
        start = 0;
        checkOutput("t1.start");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus();
            checkOutput("t1.run");
            check_val("t1.pc", 32'(pc), 32'(i));
        end
        check_val("t1.retired", 32'(retired), 5);
        check_val("t1.running", 32'(running), 1);

        // Test 2: taken / not-taken branch at pc=3
        lut_mem[5] = 12'd3;
        lut_mem[2] = 12'd34;
        jump_en = 1; jmp_idx = 6'd5;
        applyStimulus();
        check_val("t2.to3", 32'(pc), 3);
        jump_en = 0; branch_en = 1; cond = 1; jmp_idx = 6'd2;
        applyStimulus();
        checkOutput("t2.taken");
        check_val("t2.taken_pc", 32'(pc), 34);
        branch_en = 0; cond = 0; jump_en = 1; jmp_idx = 6'd5;
        applyStimulus();
        jump_en = 0; branch_en = 1; cond = 0; jmp_idx = 6'd2;
        applyStimulus();
        checkOutput("t2.nottaken");
        check_val("t2.nottaken_pc", 32'(pc), 4);

        // Test 3: jump to DONE_ADDR halts, requests ignored, start restarts
        clear_requests();
        jump_en = 1; jmp_idx = 6'd0;
        applyStimulus();
        checkOutput("t3.halt");
        check_val("t3.done", 32'(done), 1);
        check_val("t3.pc_frozen", 32'(pc), 4);
        jmp_idx = 6'd2; branch_en = 1; cond = 1; call_en = 1; ret_en = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t3.ignored");
        end
        check_val("t3.still_frozen", 32'(pc), 4);
        clear_requests();
        start = 1;
        applyStimulus();
        start = 0;
        checkOutput("t3.restart");
        check_val("t3.done_clr", 32'(done), 0);
        check_val("t3.retired_clr", 32'(retired), 0);

        // Test 4: stall holds everything and drops requests
        saved_pc  = int'(pc);
        saved_ret = int'(retired);
        stall = 1; jump_en = 1; jmp_idx = 6'd2;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t4.stall");
            check_val("t4.stall_pc", 32'(pc), 32'(saved_pc));
            check_val("t4.stall_ret", 32'(retired), 32'(saved_ret));
        end
        stall = 0;
        applyStimulus();
        checkOutput("t4.release");
        check_val("t4.release_pc", 32'(pc), 34);
        clear_requests();
        reset = 1;
        applyStimulus();
        reset = 0;
        checkOutput("t4.reset");
        check_val("t4.reset_running", 32'(running), 0);

        // Test 5: free-run into the sentinel address
        start = 1;
        applyStimulus();
        start = 0;
        lut_mem[7] = 12'd4093;
        jump_en = 1; jmp_idx = 6'd7;
        applyStimulus();
        jump_en = 0;
        check_val("t5.4093", 32'(pc), 4093);
        applyStimulus();
        check_val("t5.4094", 32'(pc), 4094);
        applyStimulus();
        checkOutput("t5.end");
        check_val("t5.4095", 32'(pc), 4095);
        check_val("t5.done", 32'(done), 1);

        // Test 6: call/return behaviour
        lut_mem[8] = 12'd10;
        lut_mem[9] = 12'd50;
        clear_requests();
        start = 1;
        applyStimulus();
        start = 0;
`ifdef PC_CALL_STACK_EN
        jump_en = 1; jmp_idx = 6'd8;
        applyStimulus();
        jump_en = 0; call_en = 1; jmp_idx = 6'd9;
        applyStimulus();
        check_val("t6.call", 32'(pc), 50);
        call_en = 0; ret_en = 1;
        applyStimulus();
        checkOutput("t6.ret");
        check_val("t6.ret_pc", 32'(pc), 11);
        ret_en = 0; call_en = 1; jmp_idx = 6'd9;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus();
            checkOutput("t6.nest");
            check_val("t6.nest_err", 32'(stack_err), (i == 5) ? 1 : 0);
        end
        check_val("t6.overflow_pc", 32'(pc), 50);
        clear_requests();
        jump_en = 1; jmp_idx = 6'd0;
        applyStimulus();
        jump_en = 0; start = 1;
        applyStimulus();
        start = 0;
        check_val("t6.err_clr", 32'(stack_err), 0);
        ret_en = 1;
        applyStimulus();
        checkOutput("t6.underflow");
        check_val("t6.underflow_pc", 32'(pc), 1);
        check_val("t6.underflow_err", 32'(stack_err), 1);
`else
        ret_en = 1;
        applyStimulus();
        checkOutput("t6.ret_ignored");
        check_val("t6.ret_pc", 32'(pc), 1);
        ret_en = 0; call_en = 1; jmp_idx = 6'd9;
        applyStimulus();
        check_val("t6.call_as_jump", 32'(pc), 50);
        call_en = 0; ret_en = 1;
        applyStimulus();
        checkOutput("t6.no_stack");
        check_val("t6.no_return", 32'(pc), 51);
        check_val("t6.err_tied", 32'(stack_err), 0);
`endif

        // Random traffic against the model
        for (int i = 1; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) lut_mem[i] = 12'd0;
            else if ($urandom_range(0, 7) == 0) lut_mem[i] = 12'($urandom_range(4088, 4094));
            else lut_mem[i] = 12'($urandom_range(0, 4094));
        end
        clear_requests();
        for (int i = 0; i < 800; i++) begin
            reset     = ($urandom_range(0, 99) < 2);
            start     = ($urandom_range(0, 99) < 8);
            stall     = ($urandom_range(0, 99) < 20);
            jump_en   = ($urandom_range(0, 99) < 10);
            branch_en = ($urandom_range(0, 99) < 15);
            cond      = ($urandom_range(0, 1) == 1);
            call_en   = ($urandom_range(0, 99) < 12);
            ret_en    = ($urandom_range(0, 99) < 10);
            jmp_idx   = 6'($urandom_range(0, 63));
            applyStimulus();
            checkOutput("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
